// File: rtl/fp_mul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_sched_pkg
// Brief    : Shared FP32 types and constants for the multiplier scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fp_mul_sched_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;

    typedef logic [FP_W-1:0] fp32_t;

endpackage
`default_nettype wire

// File: rtl/fp_mul_sched_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : parameterized_multiplier
// Brief    : Combinational FP32 multiplier, round-to-nearest-even, flush-to-zero.
// Revision : 1.0 - initial release
// ============================================================================
module parameterized_multiplier
    import fp_mul_sched_pkg::*;
#(
    parameter FORMAT = "FP32"
) (
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t p
);

    generate
        if (FORMAT == "FP32") begin : g_fp32
            logic              w_sign;
            logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
            logic [47:0]       w_prod;
            logic [22:0]       w_mant;
            logic              w_guard, w_sticky, w_round_up;
            logic [23:0]       w_mant_r;
            logic signed [9:0] w_exp;
            logic signed [9:0] w_exp_r;
            fp32_t             w_p;

            always_comb begin
                w_sign   = a[31] ^ b[31];
                w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
                w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
                w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
                w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
                // Subnormal inputs are flushed, so a zero exponent means zero.
                w_a_zero = (a[30:23] == 8'h00);
                w_b_zero = (b[30:23] == 8'h00);
                w_prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
                w_exp    = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(w_prod[47]);
                if (w_prod[47]) begin
                    w_mant   = w_prod[46:24];
                    w_guard  = w_prod[23];
                    w_sticky = |w_prod[22:0];
                end else begin
                    w_mant   = w_prod[45:23];
                    w_guard  = w_prod[22];
                    w_sticky = |w_prod[21:0];
                end
                w_round_up = w_guard && (w_sticky || w_mant[0]);
                w_mant_r   = {1'b0, w_mant} + 24'(w_round_up);
                w_exp_r    = w_exp + 10'(w_mant_r[23]);

                if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
                    w_p = FP_QNAN;
                end else if (w_a_inf || w_b_inf) begin
                    w_p = {w_sign, FP_POS_INF[30:0]};
                end else if (w_a_zero || w_b_zero) begin
                    w_p = {w_sign, 31'd0};
                end else if (w_exp_r >= 10'sd255) begin
                    w_p = {w_sign, FP_POS_INF[30:0]};
                end else if (w_exp_r <= 10'sd0) begin
                    w_p = {w_sign, 31'd0};
                end else begin
                    w_p = {w_sign, w_exp_r[7:0], w_mant_r[22:0]};
                end
            end

            assign p = w_p;
        end else begin : g_unsupported
            assign p = FP_QNAN;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fp_mul_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; searches upward from ptr, wraps modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [NUM_REQ-1:0] w_upper;
    logic               w_upper_hit;
    logic [ID_W-1:0]    w_upper_idx;
    logic [ID_W-1:0]    w_lower_idx;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        w_upper     = '0;
        w_upper_hit = 1'b0;
        w_upper_idx = '0;
        w_lower_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_upper[i] = req[i] && (i >= int'(ptr));
            if (w_upper[i]) begin
                w_upper_hit = 1'b1;
                w_upper_idx = ID_W'(i);
            end
            if (req[i]) begin
                w_lower_idx = ID_W'(i);
            end
        end
    end

    assign grant_valid = |req;
    assign grant_idx   = w_upper_hit ? w_upper_idx : w_lower_idx;
    assign grant       = (grant_valid && en) ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/fp_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_sched
// Brief    : Round-robin scheduler sharing one FP32 multiplier over NUM_REQ ports.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_sched
    import fp_mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_result,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy,
    output logic [31:0]             ops_done
);

    typedef struct packed {
        fp32_t           a;
        fp32_t           b;
        logic [ID_W-1:0] id;
    } mul_op_t;

    mul_op_t            r_s1;
    logic               r_s1_valid;
    fp32_t              r_s2_result;
    logic [ID_W-1:0]    r_s2_id;
    logic               r_s2_valid;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [31:0]        r_ops_done;

    logic               w_s2_free;
    logic               w_s1_adv;
    logic               w_s1_free;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_valid;
    logic               w_accept;
    logic [ID_W-1:0]    w_next_ptr;
    fp32_t              w_sel_a;
    fp32_t              w_sel_b;
    fp32_t              w_product;

    assign w_s2_free = !r_s2_valid || resp_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign w_s1_free = !r_s1_valid || w_s1_adv;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req         (req_valid),
        .ptr         (r_rr_ptr),
        .en          (w_s1_free),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign req_ready  = w_grant;
    assign w_accept   = w_grant_valid && w_s1_free;
    assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[32*i +: 32];
                w_sel_b = req_b[32*i +: 32];
            end
        end
    end

    parameterized_multiplier #(
        .FORMAT ("FP32")
    ) u_mul (
        .a (r_s1.a),
        .b (r_s1.b),
        .p (w_product)
    );

    // Accept and advance are evaluated independently so a drain, shift and fill share one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= '0;
            r_s1_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_id     <= '0;
            r_s2_valid  <= 1'b0;
            r_rr_ptr    <= '0;
            r_ops_done  <= '0;
        end else begin
            if (w_accept) begin
                r_s1       <= '{a: w_sel_a, b: w_sel_b, id: w_grant_idx};
                r_s1_valid <= 1'b1;
                r_rr_ptr   <= w_next_ptr;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_result <= w_product;
                r_s2_id     <= r_s1.id;
                r_s2_valid  <= 1'b1;
            end else if (resp_ready) begin
                r_s2_valid  <= 1'b0;
            end

            if (r_s2_valid && resp_ready) begin
                r_ops_done <= r_ops_done + 32'd1;
            end
        end
    end

    assign resp_valid  = r_s2_valid;
    assign resp_result = r_s2_result;
    assign resp_id     = r_s2_id;
    assign busy        = r_s1_valid || r_s2_valid;
    assign ops_done    = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_sched
// Brief    : Scoreboard testbench for the shared FP32 multiplier scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_sched;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_result;
    logic [ID_W-1:0] resp_id;
    logic            busy;
    logic [31:0]     ops_done;

    fp_mul_sched #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_id     (resp_id),
        .busy        (busy),
        .ops_done    (ops_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_tbl [N];
    logic [31:0] q_res [$];
    int          q_id  [$];
    logic [N-1:0] acc_mask = '0;
    logic [N-1:0] one_shot = '0;
    int          exp_ops  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        exp_tbl[i]        = e;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy && q_res.size() == 0) break;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_sb", 32'(q_res.size()), 32'd0);
        @(negedge clk);
        check("ops_done", ops_done, 32'(exp_ops));
    endtask

    // Scoreboard: expected results queued at accept, compared at response handshake.
    always @(negedge clk) begin
        if (rst) begin
            acc_mask = '0;
        end else begin
            acc_mask = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) begin
                    q_res.push_back(exp_tbl[i]);
                    q_id.push_back(i);
                end
            end
            if (resp_valid && resp_ready) begin
                if (q_res.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("resp_result", resp_result, q_res.pop_front());
                    check("resp_id", 32'(resp_id), 32'(q_id.pop_front()));
                end
                exp_ops++;
            end
        end
    end

    // One-shot requesters withdraw after their request is accepted.
    always @(posedge clk) begin
        #1;
        req_valid = req_valid & ~(acc_mask & one_shot);
    end

    initial begin
        #300000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n_acc;
        logic got3;
        logic [31:0] held;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        for (int i = 0; i < N; i++) exp_tbl[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ops_done", ops_done, 32'd0);
        check("rst_result", resp_result, 32'd0);

        // Round-robin with all requesters continuously valid.
        tick();
        for (int i = 0; i < N; i++) begin
            if (i % 2 == 0) set_op(i, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
            else            set_op(i, 32'hBF800000, 32'h40800000, 32'hC0800000);
        end
        one_shot = '0; resp_ready = 1'b1; req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
        end
        tick();
        req_valid = '0;
        wait_drain();

        // Single op with latency check.
        tick();
        one_shot = 4'b0100;
        set_op(2, 32'h40000000, 32'h40400000, 32'h40C00000);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'h4);
        @(negedge clk);
        check("single_lat1", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("single_lat2", 32'(resp_valid), 32'd1);
        check("single_result", resp_result, 32'h40C00000);
        check("single_id", 32'(resp_id), 32'd2);
        wait_drain();

        // Backpressure: two accepts fill the pipe, third requester must stall.
        tick();
        resp_ready = 1'b0; one_shot = 4'b0111;
        set_op(0, 32'h40000000, 32'h40400000, 32'h40C00000);
        set_op(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
        set_op(2, 32'hBF800000, 32'h40800000, 32'hC0800000);
        req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        check("bp_blocked", 32'(req_ready), 32'd0);
        check("bp_valid", 32'(resp_valid), 32'd1);
        held = resp_result;
        check("bp_first", held, q_res[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_result", resp_result, held);
        end
        tick();
        resp_ready = 1'b1;
        wait_drain();

        // Special values pass through unchanged.
        tick();
        one_shot = 4'b0111;
        set_op(0, 32'hFF800000, 32'h40000000, 32'hFF800000);
        set_op(1, 32'h7F800000, 32'h40000000, 32'h7F800000);
        set_op(2, 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        req_valid = 4'b0111;
        wait_drain();

        // Reset with both stages full.
        tick();
        resp_ready = 1'b0; one_shot = 4'b0110;
        set_op(1, 32'h40000000, 32'h40000000, 32'h40800000);
        set_op(2, 32'h40400000, 32'h40400000, 32'h41100000);
        req_valid = 4'b0110;
        repeat (4) @(negedge clk);
        check("prerst_busy", 32'(busy), 32'd1);
        check("prerst_valid", 32'(resp_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_res.delete(); q_id.delete(); exp_ops = 0;
        one_shot = '1; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 32'h40000000, 32'h3F800000, 32'h40000000);
        req_valid = '1;
        @(negedge clk);
        check("mrst_resp_valid", 32'(resp_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ops_done", ops_done, 32'd0);
        check("mrst_grant", 32'(req_ready), 32'd1);
        wait_drain();

        // Fairness: requester 0 always valid, requester 3 joins later.
        tick();
        one_shot = 4'b1000;
        set_op(0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        set_op(3, 32'hC0000000, 32'h40000000, 32'hC0800000);
        req_valid = 4'b0001;
        repeat (5) tick();
        req_valid[3] = 1'b1;
        n_acc = 0; got3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) n_acc++;
            if (req_valid[3] && req_ready[3]) begin
                n_acc++;
                got3 = 1'b1;
                break;
            end
        end
        check("fair_within_n", 32'(got3 && n_acc <= N), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
